tdm_block_scheduler: RTL and testbench

- Sequences the TDM-to-MCU bit exchange in the clk50 domain.
- Detects c4/f0 timing and produces a per-bit strobe and buffer bit index for the TDM shift datapath.
- Manages ping-pong bank ownership between the TDM side and the MCU side.
- Raises cpu_int when a block completes and flags overrun and frame-alignment errors.

---
 rtl/tdm_block_scheduler.sv | 171 +++++++++++++++++
 tb/tb_tdm_block_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_block_scheduler.sv
// TDM block scheduler: synchronises c4/f0 into the clk50 domain, issues a
// per-bit strobe with its buffer index, and hands ping-pong banks between
// the TDM shift datapath and the MCU, raising cpu_int per completed block.
module tdm_block_scheduler #(
  parameter int FRAME_BITS       = 32,
  parameter int FRAMES_PER_BLOCK = 2,
  parameter int INT_WIDTH        = 4,
  parameter int IDX_W            = $clog2(FRAME_BITS * FRAMES_PER_BLOCK)
) (
  input  logic             clk50,
  input  logic             reset_n,
  input  logic             c4,
  input  logic             f0,
  input  logic             enable,
  input  logic             mcu_release,
  input  logic             clear_err,
  output logic             bit_strobe,
  output logic [IDX_W-1:0] bit_index,
  output logic             tdm_bank,
  output logic             mcu_bank,
  output logic             cpu_int,
  output logic             overrun,
  output logic             frame_err,
  output logic             locked
);

  localparam int POS_W = $clog2(2 * FRAME_BITS);
  localparam int FC_W  = (FRAMES_PER_BLOCK > 1) ? $clog2(FRAMES_PER_BLOCK) : 1;
  localparam int IC_W  = $clog2(INT_WIDTH + 1);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(2 * FRAME_BITS - 1);
  localparam logic [POS_W-1:0] POS_DONE = POS_W'(2 * FRAME_BITS - 2);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAMES_PER_BLOCK - 1);
  localparam logic [IC_W-1:0]  IC_LOAD  = IC_W'(INT_WIDTH);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic             c4_s1, c4_s2, c4_s3;
  logic             f0_s1, f0_s2;
  logic             c4_rise;

  logic [0:0]       state, state_nx;
  logic [POS_W-1:0] pos, pos_nx;
  logic [FC_W-1:0]  frame_cnt, fc_nx;
  logic             strobe_nx;
  logic [IDX_W-1:0] idx_nx;
  logic             done_nx, done_p1;
  logic             ferr_set;

  logic             mcu_busy, busy_nx;
  logic             bank_nx;
  logic [IC_W-1:0]  int_cnt, ic_nx;
  logic             ovr_set;

  // Two-flop synchronisers for c4/f0 plus a third c4 flop for edge detect.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      c4_s1 <= 1'b0;
      c4_s2 <= 1'b0;
      c4_s3 <= 1'b0;
      f0_s1 <= 1'b0;
      f0_s2 <= 1'b0;
    end else begin
      c4_s1 <= c4;
      c4_s2 <= c4_s1;
      c4_s3 <= c4_s2;
      f0_s1 <= f0;
      f0_s2 <= f0_s1;
    end
  end

  assign c4_rise = c4_s2 & ~c4_s3;

  // Frame tracking: HUNT/RUN decisions, position counting and strobe generation.
  always_comb begin
    state_nx  = state;
    pos_nx    = pos;
    fc_nx     = frame_cnt;
    strobe_nx = 1'b0;
    idx_nx    = bit_index;
    done_nx   = 1'b0;
    ferr_set  = 1'b0;
    if (!enable) begin
      state_nx = HUNT;
      pos_nx   = '0;
      fc_nx    = '0;
    end else if (c4_rise) begin
      if (state == HUNT) begin
        if (!f0_s2) begin
          state_nx = RUN;
          pos_nx   = '0;
          fc_nx    = '0;
        end
      end else if (!f0_s2) begin
        // f0 low is only legal at the frame boundary; anywhere else we lost alignment.
        if (pos != '0) begin
          ferr_set = 1'b1;
          state_nx = HUNT;
          pos_nx   = '0;
          fc_nx    = '0;
        end
      end else begin
        if (!pos[0]) begin
          strobe_nx = 1'b1;
          idx_nx    = IDX_W'(frame_cnt) * IDX_W'(FRAME_BITS) + IDX_W'(pos >> 1);
          done_nx   = (pos == POS_DONE) && (frame_cnt == FC_LAST);
        end
        if (pos == POS_LAST) begin
          pos_nx = '0;
          fc_nx  = (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
        end else begin
          pos_nx = pos + 1'b1;
        end
      end
    end
  end

  // Bank handover, MCU ownership and interrupt length, evaluated on the block-done strobe cycle.
  always_comb begin
    busy_nx = mcu_busy & ~mcu_release;
    bank_nx = tdm_bank;
    ic_nx   = (int_cnt != '0) ? int_cnt - 1'b1 : int_cnt;
    ovr_set = 1'b0;
    if (done_p1) begin
      if (mcu_release || !mcu_busy) begin
        bank_nx = ~tdm_bank;
        busy_nx = 1'b1;
        ic_nx   = IC_LOAD;
      end else begin
        ovr_set = 1'b1;
      end
    end
  end

  // Stage p1: registered outputs and controller state.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HUNT;
      pos        <= '0;
      frame_cnt  <= '0;
      bit_strobe <= 1'b0;
      bit_index  <= '0;
      done_p1    <= 1'b0;
      locked     <= 1'b0;
      mcu_busy   <= 1'b0;
      tdm_bank   <= 1'b0;
      mcu_bank   <= 1'b1;
      int_cnt    <= '0;
      cpu_int    <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      pos        <= pos_nx;
      frame_cnt  <= fc_nx;
      bit_strobe <= strobe_nx;
      bit_index  <= idx_nx;
      done_p1    <= done_nx;
      locked     <= (state_nx == RUN);
      mcu_busy   <= busy_nx;
      tdm_bank   <= bank_nx;
      mcu_bank   <= ~bank_nx;
      int_cnt    <= ic_nx;
      cpu_int    <= (ic_nx != '0);
      overrun    <= ovr_set | (overrun & ~clear_err);
      frame_err  <= ferr_set | (frame_err & ~clear_err);
    end
  end

endmodule

// File: tb/tb_tdm_block_scheduler.sv
// Directed bench for tdm_block_scheduler: block-level table plus hand
// sequences for misalignment, async reset during cpu_int and enable drop.
module tb_tdm_block_scheduler;

  logic       clk50;
  logic       reset_n;
  logic       c4;
  logic       f0;
  logic       enable;
  logic       mcu_release;
  logic       clear_err;
  logic       bit_strobe;
  logic [5:0] bit_index;
  logic       tdm_bank;
  logic       mcu_bank;
  logic       cpu_int;
  logic       overrun;
  logic       frame_err;
  logic       locked;

  int checks;
  int errors;
  int int_acc;

  typedef struct {
    bit rel_before;
    bit clr_before;
    bit rel_at_done;
    bit exp_bank;
    int exp_ints;
    bit exp_ovr;
  } blk_vec_t;

  blk_vec_t tbl[6];

  tdm_block_scheduler #(
    .FRAME_BITS(32),
    .FRAMES_PER_BLOCK(2),
    .INT_WIDTH(4)
  ) dut (
    .clk50(clk50),
    .reset_n(reset_n),
    .c4(c4),
    .f0(f0),
    .enable(enable),
    .mcu_release(mcu_release),
    .clear_err(clear_err),
    .bit_strobe(bit_strobe),
    .bit_index(bit_index),
    .tdm_bank(tdm_bank),
    .mcu_bank(mcu_bank),
    .cpu_int(cpu_int),
    .overrun(overrun),
    .frame_err(frame_err),
    .locked(locked)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One c4 period of 12 clk50 cycles; observes strobes and cpu_int.
  task automatic do_rise(input logic f0v, input logic rel, output int n,
                         output int k_at, output logic [5:0] idx, output int ints);
    n = 0; k_at = 0; idx = '0; ints = 0;
    c4 = 1'b1;
    f0 = f0v;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk50); #1;
      if (bit_strobe) begin
        n++;
        k_at = k;
        idx = bit_index;
      end
      if (cpu_int) ints++;
      if (k == 3) mcu_release = rel;
      if (k == 4) mcu_release = 1'b0;
      if (k == 6) c4 = 1'b0;
    end
  endtask

  task automatic f0_rise();
    int n, k, ints;
    logic [5:0] idx;
    do_rise(1'b0, 1'b0, n, k, idx, ints);
    int_acc += ints;
    chk("f0low_strobe", n, 0);
    chk("locked_after_f0", locked, 1);
  endtask

  task automatic run_rises(input int fr, input int r_from, input int r_to, input logic rel_done);
    int n, k, ints;
    logic [5:0] idx;
    for (int r = r_from; r <= r_to; r++) begin
      do_rise(1'b1, rel_done && (fr == 1) && (r == 62), n, k, idx, ints);
      int_acc += ints;
      if (r % 2 == 0) begin
        chk("strobe_cnt", n, 1);
        chk("strobe_latency", k, 3);
        chk("bit_index", idx, fr * 32 + r / 2);
      end else begin
        chk("odd_pos_strobe", n, 0);
      end
    end
  endtask

  task automatic pulse_release();
    mcu_release = 1'b1;
    @(posedge clk50); #1;
    mcu_release = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(posedge clk50); #1;
    clear_err = 1'b0;
  endtask

  task automatic run_block(input blk_vec_t v);
    if (v.rel_before) pulse_release();
    if (v.clr_before) begin
      pulse_clear();
      chk("overrun_cleared", overrun, 0);
    end
    int_acc = 0;
    for (int fr = 0; fr < 2; fr++) begin
      f0_rise();
      run_rises(fr, 0, 63, v.rel_at_done);
    end
    chk("blk_tdm_bank", tdm_bank, v.exp_bank);
    chk("blk_mcu_bank", mcu_bank, !v.exp_bank);
    chk("blk_cpu_int_cycles", int_acc, v.exp_ints);
    chk("blk_overrun", overrun, v.exp_ovr);
    chk("blk_frame_err", frame_err, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, ints;
    logic [5:0] idx;
    logic saved_bank;
    checks = 0; errors = 0; int_acc = 0;

    //                rel_b clr_b rel_d bank ints ovr
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0}; // first swap
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1}; // overrun, no swap
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b1}; // released, swap back, sticky overrun
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 4, 1'b0}; // release on block-done cycle
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1}; // overrun again
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b1}; // swap to bank 0

    reset_n = 1'b0; c4 = 1'b0; f0 = 1'b1; enable = 1'b1;
    mcu_release = 1'b0; clear_err = 1'b0;
    repeat (3) @(posedge clk50);
    #1;
    chk("rst_bit_strobe", bit_strobe, 0);
    chk("rst_bit_index", bit_index, 0);
    chk("rst_tdm_bank", tdm_bank, 0);
    chk("rst_mcu_bank", mcu_bank, 1);
    chk("rst_cpu_int", cpu_int, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_locked", locked, 0);
    reset_n = 1'b1;
    @(posedge clk50); #1;

    // HUNT ignores high-f0 edges: no strobes, not locked.
    do_rise(1'b1, 1'b0, n, k, idx, ints);
    chk("hunt_strobe", n, 0);
    chk("hunt_locked", locked, 0);

    for (int i = 0; i < 6; i++) run_block(tbl[i]);

    // Misaligned f0 at pos 10.
    f0_rise();
    run_rises(0, 0, 9, 1'b0);
    saved_bank = tdm_bank;
    do_rise(1'b0, 1'b0, n, k, idx, ints);
    chk("misalign_strobe", n, 0);
    chk("misalign_frame_err", frame_err, 1);
    chk("misalign_locked", locked, 0);
    for (int i = 0; i < 3; i++) begin
      do_rise(1'b1, 1'b0, n, k, idx, ints);
      chk("post_misalign_strobe", n, 0);
    end
    f0_rise();
    run_rises(0, 0, 0, 1'b0);
    chk("relock_bank", tdm_bank, saved_bank);
    chk("frame_err_sticky", frame_err, 1);
    pulse_clear();
    chk("frame_err_cleared", frame_err, 0);

    // Finish this block with the MCU released, then reset during cpu_int.
    pulse_release();
    run_rises(0, 1, 63, 1'b0);
    f0_rise();
    run_rises(1, 0, 61, 1'b0);
    c4 = 1'b1; f0 = 1'b1;
    for (int kk = 1; kk <= 5; kk++) begin
      @(posedge clk50); #1;
      if (kk == 3) begin
        chk("done_strobe", bit_strobe, 1);
        chk("done_index", bit_index, 63);
      end
    end
    chk("pre_rst_cpu_int", cpu_int, 1);
    chk("pre_rst_tdm_bank", tdm_bank, 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_cpu_int", cpu_int, 0);
    chk("async_rst_tdm_bank", tdm_bank, 0);
    chk("async_rst_mcu_bank", mcu_bank, 1);
    chk("async_rst_locked", locked, 0);
    c4 = 1'b0;
    repeat (2) @(posedge clk50);
    #1;
    reset_n = 1'b1;
    @(posedge clk50); #1;

    // Enable drop mid-frame.
    f0_rise();
    run_rises(0, 0, 7, 1'b0);
    enable = 1'b0;
    @(posedge clk50); #1;
    chk("disable_locked", locked, 0);
    for (int i = 0; i < 4; i++) begin
      do_rise(1'b1, 1'b0, n, k, idx, ints);
      chk("disable_strobe", n, 0);
    end
    chk("disable_tdm_bank", tdm_bank, 0);
    chk("disable_mcu_bank", mcu_bank, 1);
    enable = 1'b1;
    f0_rise();
    run_rises(0, 0, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
